seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_if.sv | 17 +
 rtl/seq_mul.sv | 106 ++++++++++
 tb/tb_seq_mul.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_mul_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
interface seq_mul_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   p;

   modport master (output start, output signed_mode, output a, output b,
                   input busy, input done, input p);
   modport slave  (input start, input signed_mode, input a, input b,
                   output busy, output done, output p);
endinterface

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// signed operands handled as magnitudes with the sign re-applied at the end.
module seq_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   seq_mul_if.slave   bus
);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [PW-1:0]    r_mcand, w_mcand_nxt;
   logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
   logic [PW-1:0]    r_acc, w_acc_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_neg, w_neg_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic [PW-1:0]    r_p, w_p_nxt;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [PW-1:0]    w_sum;

   // The most negative operand's magnitude still fits in WIDTH unsigned bits.
   assign w_a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
   assign w_b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;
   assign w_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_p      <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_mcand  <= w_mcand_nxt;
         r_mplier <= w_mplier_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_neg    <= w_neg_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_p      <= w_p_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mcand_nxt  = r_mcand;
      w_mplier_nxt = r_mplier;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_neg_nxt    = r_neg;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_p_nxt      = r_p;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_mcand_nxt  = PW'(w_a_mag);
               w_mplier_nxt = w_b_mag;
               w_acc_nxt    = '0;
               w_cnt_nxt    = '0;
               w_neg_nxt    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               w_busy_nxt   = 1'b1;
               w_state_nxt  = CALC;
            end
         end
         CALC: begin
            w_acc_nxt    = w_sum;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt + CW'(1);
            // Last bit: publish the finished sum directly, sign applied.
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_p_nxt     = r_neg ? (PW'(0) - w_sum) : w_sum;
               w_done_nxt  = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_busy_nxt = 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.p    = r_p;
endmodule

// File: tb/tb_seq_mul.sv
// Randomized self-checking bench for seq_mul against an arithmetic product model.
module tb_seq_mul;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   seq_mul_if #(.WIDTH(8)) bus ();

   seq_mul #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic sm);
      longint x, y;
      x = sm ? longint'($signed(a)) : longint'(a);
      y = sm ? longint'($signed(b)) : longint'(b);
      return 16'(x * y);
   endfunction

   task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input bit scramble);
      logic [15:0] exp, p_prev;
      int cyc, nbusy;
      exp    = ref_mul(a, b, sm);
      p_prev = bus.p;
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.signed_mode = sm;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0; nbusy = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) nbusy++;
         check("p_hold", 32'(bus.p), 32'(p_prev));
         if (scramble) begin
            bus.start = 1'($urandom); bus.a = 8'($urandom);
            bus.b = 8'($urandom); bus.signed_mode = 1'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'd8);
      check("busy_cycles", 32'(nbusy), 32'd8);
      check("product", 32'(bus.p), 32'(exp));
      check("busy_with_done", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("p_after_done", 32'(bus.p), 32'(exp));
   endtask

   initial begin
      logic [15:0] q[$];
      logic [15:0] p_last;
      logic [7:0]  ra, rb;
      logic        rs;
      int cyc, last, ndone;
      n_tests = 0; n_fail = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_p", 32'(bus.p), 32'd0);
      rst = 1'b0;

      do_mul(8'h0F, 8'h0F, 1'b0, 1'b0);
      do_mul(8'hFF, 8'hFF, 1'b0, 1'b0);
      do_mul(8'h00, 8'hA5, 1'b0, 1'b0);
      do_mul(8'hFD, 8'h05, 1'b1, 1'b0);
      do_mul(8'h80, 8'h80, 1'b1, 1'b0);
      do_mul(8'hFF, 8'hFF, 1'b1, 1'b0);
      do_mul(8'h7F, 8'h80, 1'b1, 1'b1);
      do_mul(8'hC3, 8'h00, 1'b1, 1'b1);

      for (int i = 0; i < 24; i++)
         do_mul(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

      // Abort in the fourth CALC cycle; no result may follow.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.signed_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_p", 32'(bus.p), 32'd0);
      bus.start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("start_in_rst", 32'(bus.busy), 32'd0);
      end
      rst = 1'b0; bus.start = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("no_done_after_abort", 32'(bus.done), 32'd0);
      end
      do_mul(8'h5A, 8'h3C, 1'b0, 1'b0);

      // Back-to-back with start held high.
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      q.push_back(ref_mul(ra, rb, rs));
      p_last = bus.p;
      @(negedge clk);
      bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.signed_mode = rs;
      cyc = 0; last = 0; ndone = 0;
      while (ndone < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            check("b2b_gap", 32'(cyc - last), (ndone == 0) ? 32'd9 : 32'd10);
            check("b2b_product", 32'(bus.p), 32'(q.pop_front()));
            p_last = bus.p;
            last = cyc;
            ndone++;
            if (ndone < 3) begin
               ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
               bus.a = ra; bus.b = rb; bus.signed_mode = rs;
               q.push_back(ref_mul(ra, rb, rs));
            end else begin
               bus.start = 1'b0;
            end
         end else begin
            check("b2b_p_hold", 32'(bus.p), 32'(p_last));
         end
      end
      check("b2b_count", 32'(ndone), 32'd3);
      repeat (3) @(negedge clk);
      check("idle_p_hold", 32'(bus.p), 32'(p_last));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
